distance_unloader: RTL and testbench
====================================

# distance_unloader

Downstream stage of `bellmanford`. Once the solver raises `Finish`, it reads the output memory through its read port (`OMAR`/`OMDR`), one 16-bit distance per node. It streams each entry out over a valid/ready interface, tagged with its node index, and accumulates summary statistics (reachable-node count, maximum finite distance). If the solver raises `NegCycle`, it reports a negative cycle and streams nothing.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: output-memory address width.
- `DATA_WIDTH`, 16: distance width.
- `NUM_NODES`, 8192: entries streamed, from index 0 to NUM_NODES-1. Must be ≤ 2^ADDR_WIDTH.
- `UNREACH`, 16'hFFFF: marker for an unreachable node.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `Finish`  in  1: solver-complete level from `bellmanford`.
- `NegCycle`  in  1: negative-cycle level from `bellmanford`.
- `OMAR`  out  ADDR_WIDTH: output-memory read address (registered).
- `OMDR`  in  DATA_WIDTH: output-memory read data, combinational from `OMAR`.
- `OutValid`  out  1: stream word valid.
- `OutReady`  in  1: consumer accepts the word when `OutValid` && `OutReady` at a rising edge.
- `OutData`  out  DATA_WIDTH: distance.
- `OutIndex`  out  ADDR_WIDTH: node index of `OutData`.
- `OutLast`  out  1: high with the word for index NUM_NODES-1.
- `Reachable`  out  ADDR_WIDTH+1: count of streamed entries ≠ UNREACH.
- `MaxDist`  out  DATA_WIDTH: largest streamed entry ≠ UNREACH; 0 if there are none.
- `NegFlag`  out  1: negative cycle reported.
- `Done`  out  1: unload or negative-cycle report is complete.

## Operation
- FSM states: IDLE, SCAN, DONE, NEG.
- **IDLE**
  - Waits for a trigger.
  - `NegCycle`=1 → NEG. This has priority, including when `Finish`=1 in the same cycle.
  - Otherwise `Finish`=1 → SCAN. `OMAR`, `Reachable` and `MaxDist` are cleared on this transition.
- **SCAN**
  - The output register is loadable when `OutValid`=0 or `OutReady`=1.
  - On a load: `OutData`←`OMDR`, `OutIndex`←`OMAR`, `OutValid`←1, `OutLast`←(`OMAR`==NUM_NODES-1).
  - Also on a load, `OMAR` increments. It saturates at NUM_NODES-1 and does not wrap.
  - Statistics update at load time:
    - If `OMDR` ≠ UNREACH: `Reachable`+=1 and `MaxDist`←max(`MaxDist`, `OMDR`).
    - UNREACH entries are streamed but not counted.
  - Once the NUM_NODES-1 word is loaded, no further loads occur.
  - When that last word is accepted (valid&&ready&&`OutLast`): `OutValid`←0 and → DONE.
  - `NegCycle` rising during SCAN: abort, `OutValid`←0, → NEG. Statistics freeze at their current values.
- **DONE**
  - `Done`=1; statistics are held.
  - `Finish`=0 → IDLE. `Done` drops; statistics are held until the next SCAN entry.
- **NEG**
  - `NegFlag`=1, `Done`=1, `OutValid`=0.
  - Leaves only on `reset`.
- `OutData`, `OutIndex` and `OutLast` are stable while `OutValid`=1 and `OutReady`=0.
- Arithmetic is unsigned. The `Reachable` width covers a count of NUM_NODES and cannot overflow.

## Timing
- Reset values of all outputs are 0: `OMAR`, `OutValid`, `OutData`, `OutIndex`, `OutLast`, `Reachable`, `MaxDist`, `NegFlag`, `Done`. The state is IDLE.
- `reset` is asynchronous, so its assertion mid-SCAN clears everything immediately. Release is synchronised by the user.
- Latency:
  - `Finish` sampled high at edge N moves the FSM to SCAN.
  - The first load happens at edge N+1: `OutValid`=1 and `OutIndex`=0 after N+1.
- Throughput: one word per cycle while `OutReady`=1.
- With `OutReady` held high:
  - The last word is valid after edge N+NUM_NODES.
  - `Done`=1 after edge N+NUM_NODES+1.
- Backpressure: while `OutValid`=1 and `OutReady`=0, nothing loads and `OMAR` holds.
- `NegCycle` is sampled synchronously. `NegFlag` and `Done` go high one edge after `NegCycle` is sampled high.
- Simultaneous acceptance of the last word and `NegCycle`=1 → NEG. The word counts as accepted.

## Test plan
- Basic unload:
  - Stimulus: NUM_NODES=8; memory {0,5,FFFF,3,12,FFFF,7,1}; `Finish`↑; `OutReady`=1.
  - Response: 8 words in indices 0..7 on consecutive cycles; `OutLast` only on index 7; then `Done`=1, `Reachable`=6, `MaxDist`=12.
- Backpressure:
  - Stimulus: same memory; `OutReady` toggles 1,0,0,1,...
  - Response: the word sequence is identical to the basic case with no duplicates or drops; `OutData` is stable during stalls; `OMAR` never exceeds 7.
- Negative cycle in IDLE:
  - Stimulus: `NegCycle`=1 and `Finish`=1 in the same cycle.
  - Response: next edge `NegFlag`=1, `Done`=1; `OutValid` never asserts.
- Abort mid-scan:
  - Stimulus: `NegCycle`↑ after 3 words accepted.
  - Response: `OutValid`→0, `NegFlag`=1, `Reachable` frozen at the count of entries loaded so far.
- All unreachable:
  - Stimulus: NUM_NODES=4, memory all FFFF.
  - Response: 4 words of FFFF streamed; `Reachable`=0, `MaxDist`=0, `Done`=1.
- Reset mid-SCAN, then rerun:
  - Stimulus: `reset`=0 asynchronously at word 2, then release and `Finish`↑ again.
  - Response: all outputs are 0 during reset; the second run streams from index 0 with fresh statistics.

Source files
------------

// File: rtl/distance_unloader_if.sv
// ---------------------------------------------------------------------------
// distance_unloader_if
//   Bundles every non-clock signal of distance_unloader: the solver trigger
//   levels, the output-memory read port, the valid/ready result stream and
//   the status/statistics outputs.
//
//   Signals:
//     Finish, NegCycle  solver levels from bellmanford
//     OMAR / OMDR       output-memory read address / combinational read data
//     OutValid/OutReady stream handshake
//     OutData/OutIndex  distance and its node index
//     OutLast           marks the word for the final node
//     Reachable/MaxDist summary statistics
//     NegFlag / Done    status
//
//   Modports:
//     master  the unloader side
//     slave   the environment side (solver, memory, consumer)
// ---------------------------------------------------------------------------
interface distance_unloader_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
) ();

  logic                  Finish;
  logic                  NegCycle;
  logic [ADDR_WIDTH-1:0] OMAR;
  logic [DATA_WIDTH-1:0] OMDR;
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_WIDTH-1:0] OutData;
  logic [ADDR_WIDTH-1:0] OutIndex;
  logic                  OutLast;
  logic [ADDR_WIDTH:0]   Reachable;
  logic [DATA_WIDTH-1:0] MaxDist;
  logic                  NegFlag;
  logic                  Done;

  modport master (
    input  Finish, NegCycle, OMDR, OutReady,
    output OMAR, OutValid, OutData, OutIndex, OutLast,
           Reachable, MaxDist, NegFlag, Done
  );

  modport slave (
    output Finish, NegCycle, OMDR, OutReady,
    input  OMAR, OutValid, OutData, OutIndex, OutLast,
           Reachable, MaxDist, NegFlag, Done
  );

endinterface

// File: rtl/distance_unloader.sv
// ---------------------------------------------------------------------------
// distance_unloader
//   Downstream stage of bellmanford. After Finish it walks the solver's
//   output memory from node 0 to NUM_NODES-1 and streams each distance with
//   its node index over valid/ready, accumulating the reachable-node count
//   and the largest finite distance. A NegCycle level (from IDLE or during
//   the scan) reports a negative cycle instead; that state is left only by
//   reset.
//
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous active-low reset
//     bus    distance_unloader_if.master (trigger, memory port, stream,
//            statistics and status)
// ---------------------------------------------------------------------------
module distance_unloader #(
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    NUM_NODES  = 8192,
  parameter logic [DATA_WIDTH-1:0] UNREACH    = 16'hFFFF
) (
  input logic               clock,
  input logic               reset,
  distance_unloader_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE,
    ST_NEG
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] omar_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] out_index_q;
  logic                  out_last_q;
  logic [ADDR_WIDTH:0]   reachable_q;
  logic [DATA_WIDTH-1:0] max_dist_q;
  logic                  neg_flag_q;
  logic                  done_q;

  logic                  load;
  logic                  last_accept;
  logic                  entry_reachable;
  logic [ADDR_WIDTH-1:0] omar_d;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), so no latch can be inferred.
  always_comb begin
    last_accept     = out_valid_q && bus.OutReady && out_last_q;
    // The output register is free when empty or being drained; once the
    // final word sits in it nothing more is fetched.
    load            = (state_q == ST_SCAN) && !bus.NegCycle &&
                      (!out_valid_q || bus.OutReady) &&
                      !(out_valid_q && out_last_q);
    entry_reachable = (bus.OMDR != UNREACH);
    // Saturate rather than wrap so OMAR never leaves the node range.
    omar_d          = (omar_q == LAST_ADDR) ? omar_q : omar_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      omar_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      reachable_q <= '0;
      max_dist_q  <= '0;
      neg_flag_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // NegCycle wins over a simultaneous Finish.
          if (bus.NegCycle) begin
            state_q    <= ST_NEG;
            neg_flag_q <= 1'b1;
            done_q     <= 1'b1;
          end else if (bus.Finish) begin
            state_q     <= ST_SCAN;
            omar_q      <= '0;
            reachable_q <= '0;
            max_dist_q  <= '0;
          end
        end

        ST_SCAN: begin
          if (bus.NegCycle) begin
            // Abort: statistics keep whatever was loaded so far.
            state_q     <= ST_NEG;
            out_valid_q <= 1'b0;
            neg_flag_q  <= 1'b1;
            done_q      <= 1'b1;
          end else if (last_accept) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.OMDR;
            out_index_q <= omar_q;
            out_last_q  <= (omar_q == LAST_ADDR);
            omar_q      <= omar_d;
            if (entry_reachable) begin
              reachable_q <= reachable_q + 1'b1;
              if (bus.OMDR > max_dist_q) max_dist_q <= bus.OMDR;
            end
          end
        end

        ST_DONE: begin
          if (!bus.Finish) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end

        ST_NEG: begin
          // Sticky until reset.
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.OMAR      = omar_q;
  assign bus.OutValid  = out_valid_q;
  assign bus.OutData   = out_data_q;
  assign bus.OutIndex  = out_index_q;
  assign bus.OutLast   = out_last_q;
  assign bus.Reachable = reachable_q;
  assign bus.MaxDist   = max_dist_q;
  assign bus.NegFlag   = neg_flag_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_distance_unloader.sv
// ---------------------------------------------------------------------------
// tb_distance_unloader
//   Directed bench: an 8-node instance over {0,5,FFFF,3,12,FFFF,7,1} and a
//   4-node instance over an all-unreachable memory, sharing clock and reset.
//   Inputs change 1 time unit after a rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_distance_unloader;

  logic clock;
  logic reset;

  int checks   = 0;
  int failures = 0;

  distance_unloader_if #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) if8 ();
  distance_unloader_if #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) if4 ();

  distance_unloader #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .NUM_NODES(8),
                      .UNREACH(16'hFFFF))
    dut8 (.clock(clock), .reset(reset), .bus(if8.master));

  distance_unloader #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .NUM_NODES(4),
                      .UNREACH(16'hFFFF))
    dut4 (.clock(clock), .reset(reset), .bus(if4.master));

  logic [15:0] mem8 [8];
  logic [15:0] mem4 [4];

  // Out-of-range reads return a poison value so an overrun cannot hide.
  assign if8.OMDR = (if8.OMAR < 13'd8) ? mem8[if8.OMAR[2:0]] : 16'hDEAD;
  assign if4.OMDR = (if4.OMAR < 13'd4) ? mem4[if4.OMAR[1:0]] : 16'hDEAD;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [75:0] outs8();
    return {if8.OMAR, if8.OutValid, if8.OutData, if8.OutIndex, if8.OutLast,
            if8.Reachable, if8.MaxDist, if8.NegFlag, if8.Done};
  endfunction

  function automatic logic [75:0] outs4();
    return {if4.OMAR, if4.OutValid, if4.OutData, if4.OutIndex, if4.OutLast,
            if4.Reachable, if4.MaxDist, if4.NegFlag, if4.Done};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (outs8() !== '0) begin
      failures++;
      $display("FAIL reset_outs8: got %h expected 0", outs8());
    end
    checks++;
    if (outs4() !== '0) begin
      failures++;
      $display("FAIL reset_outs4: got %h expected 0", outs4());
    end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    if8.Finish   = 1'b1;
    if8.OutReady = 1'b1;
    step();  // edge N: IDLE -> SCAN
    checks++;
    if (if8.OutValid !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: OutValid got %b expected 0", if8.OutValid);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (if8.OutValid !== 1'b1 || if8.OutIndex !== 13'(k) ||
          if8.OutData !== mem8[k] || if8.OutLast !== (k == 7)) begin
        failures++;
        $display("FAIL basic_word%0d: got v=%b i=%0d d=%h l=%b expected v=1 i=%0d d=%h l=%b",
                 k, if8.OutValid, if8.OutIndex, if8.OutData, if8.OutLast,
                 k, mem8[k], (k == 7));
      end
    end
    step();
    checks++;
    if (if8.Done !== 1'b1 || if8.OutValid !== 1'b0 ||
        if8.Reachable !== 14'd6 || if8.MaxDist !== 16'd12) begin
      failures++;
      $display("FAIL basic_done: got done=%b v=%b reach=%0d max=%0d expected 1 0 6 12",
               if8.Done, if8.OutValid, if8.Reachable, if8.MaxDist);
    end
    if8.Finish = 1'b0;
    step();
    checks++;
    if (if8.Done !== 1'b0 || if8.Reachable !== 14'd6 || if8.MaxDist !== 16'd12) begin
      failures++;
      $display("FAIL basic_idle_hold: got done=%b reach=%0d max=%0d expected 0 6 12",
               if8.Done, if8.Reachable, if8.MaxDist);
    end
  endtask

  task automatic test_backpressure();
    int          got;
    logic        stalled;
    logic [15:0] sv_data;
    logic [12:0] sv_index;
    logic        sv_last;
    got     = 0;
    stalled = 1'b0;
    sv_data = '0; sv_index = '0; sv_last = 1'b0;
    if8.Finish = 1'b1;
    step();
    for (int cyc = 0; cyc < 60 && if8.Done !== 1'b1; cyc++) begin
      if8.OutReady = (cyc % 3 == 0);
      checks++;
      if (if8.OMAR > 13'd7) begin
        failures++;
        $display("FAIL bp_omar_range: got %0d expected <= 7", if8.OMAR);
      end
      if (stalled) begin
        checks++;
        if (if8.OutValid !== 1'b1 || if8.OutData !== sv_data ||
            if8.OutIndex !== sv_index || if8.OutLast !== sv_last) begin
          failures++;
          $display("FAIL bp_stall_stable: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                   if8.OutValid, if8.OutData, if8.OutIndex, if8.OutLast,
                   sv_data, sv_index, sv_last);
        end
      end
      if (if8.OutValid === 1'b1 && if8.OutReady === 1'b1) begin
        checks++;
        if (got > 7 || if8.OutIndex !== 13'(got) || if8.OutData !== mem8[got[2:0]] ||
            if8.OutLast !== (got == 7)) begin
          failures++;
          $display("FAIL bp_word%0d: got i=%0d d=%h l=%b", got,
                   if8.OutIndex, if8.OutData, if8.OutLast);
        end
        got++;
      end
      stalled  = (if8.OutValid === 1'b1) && !if8.OutReady;
      sv_data  = if8.OutData;
      sv_index = if8.OutIndex;
      sv_last  = if8.OutLast;
      step();
    end
    checks++;
    if (if8.Done !== 1'b1 || got != 8 || if8.Reachable !== 14'd6 ||
        if8.MaxDist !== 16'd12) begin
      failures++;
      $display("FAIL bp_summary: got done=%b words=%0d reach=%0d max=%0d expected 1 8 6 12",
               if8.Done, got, if8.Reachable, if8.MaxDist);
    end
    if8.Finish   = 1'b0;
    if8.OutReady = 1'b1;
    step();
  endtask

  task automatic test_neg_idle();
    if8.NegCycle = 1'b1;
    if8.Finish   = 1'b1;
    step();
    checks++;
    if (if8.NegFlag !== 1'b1 || if8.Done !== 1'b1 || if8.OutValid !== 1'b0) begin
      failures++;
      $display("FAIL neg_idle: got neg=%b done=%b v=%b expected 1 1 0",
               if8.NegFlag, if8.Done, if8.OutValid);
    end
    if8.NegCycle = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (if8.OutValid !== 1'b0 || if8.NegFlag !== 1'b1) begin
        failures++;
        $display("FAIL neg_idle_sticky%0d: got v=%b neg=%b expected 0 1",
                 k, if8.OutValid, if8.NegFlag);
      end
    end
    if8.Finish = 1'b0;
  endtask

  task automatic test_abort();
    pulse_reset();
    if8.Finish   = 1'b1;
    if8.OutReady = 1'b1;
    step();                          // SCAN
    for (int k = 0; k < 4; k++) step();  // words 0..2 accepted, word 3 shown
    checks++;
    if (if8.OutValid !== 1'b1 || if8.OutIndex !== 13'd3) begin
      failures++;
      $display("FAIL abort_pre: got v=%b i=%0d expected 1 3", if8.OutValid, if8.OutIndex);
    end
    if8.NegCycle = 1'b1;
    step();
    checks++;
    if (if8.OutValid !== 1'b0 || if8.NegFlag !== 1'b1 || if8.Done !== 1'b1 ||
        if8.Reachable !== 14'd3 || if8.MaxDist !== 16'd5) begin
      failures++;
      $display("FAIL abort: got v=%b neg=%b done=%b reach=%0d max=%0d expected 0 1 1 3 5",
               if8.OutValid, if8.NegFlag, if8.Done, if8.Reachable, if8.MaxDist);
    end
    if8.NegCycle = 1'b0;
    step();
    checks++;
    if (if8.Reachable !== 14'd3 || if8.OutValid !== 1'b0) begin
      failures++;
      $display("FAIL abort_frozen: got reach=%0d v=%b expected 3 0",
               if8.Reachable, if8.OutValid);
    end
    if8.Finish = 1'b0;
  endtask

  task automatic test_all_unreach();
    if4.Finish   = 1'b1;
    if4.OutReady = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (if4.OutValid !== 1'b1 || if4.OutIndex !== 13'(k) ||
          if4.OutData !== 16'hFFFF || if4.OutLast !== (k == 3)) begin
        failures++;
        $display("FAIL unreach_word%0d: got v=%b i=%0d d=%h l=%b expected v=1 i=%0d d=ffff l=%b",
                 k, if4.OutValid, if4.OutIndex, if4.OutData, if4.OutLast, k, (k == 3));
      end
    end
    step();
    checks++;
    if (if4.Done !== 1'b1 || if4.Reachable !== 14'd0 || if4.MaxDist !== 16'd0 ||
        if4.OMAR !== 13'd3) begin
      failures++;
      $display("FAIL unreach_done: got done=%b reach=%0d max=%0d omar=%0d expected 1 0 0 3",
               if4.Done, if4.Reachable, if4.MaxDist, if4.OMAR);
    end
    if4.Finish = 1'b0;
    step();
  endtask

  task automatic test_reset_midscan();
    pulse_reset();
    if8.Finish   = 1'b1;
    if8.OutReady = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (if8.OutIndex !== 13'd2 || if8.OutValid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got i=%0d v=%b expected 2 1", if8.OutIndex, if8.OutValid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs8() !== '0) begin
      failures++;
      $display("FAIL rst_async: got %h expected 0", outs8());
    end
    if8.Finish = 1'b0;
    step();
    checks++;
    if (outs8() !== '0) begin
      failures++;
      $display("FAIL rst_held: got %h expected 0", outs8());
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    if8.Finish = 1'b1;
    step();
    step();
    checks++;
    if (if8.OutValid !== 1'b1 || if8.OutIndex !== 13'd0 ||
        if8.Reachable !== 14'd1 || if8.MaxDist !== 16'd0) begin
      failures++;
      $display("FAIL rerun_first: got v=%b i=%0d reach=%0d max=%0d expected 1 0 1 0",
               if8.OutValid, if8.OutIndex, if8.Reachable, if8.MaxDist);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      checks++;
      if (if8.OutIndex !== 13'(k) || if8.OutData !== mem8[k]) begin
        failures++;
        $display("FAIL rerun_word%0d: got i=%0d d=%h expected i=%0d d=%h",
                 k, if8.OutIndex, if8.OutData, k, mem8[k]);
      end
    end
    step();
    checks++;
    if (if8.Done !== 1'b1 || if8.Reachable !== 14'd6 || if8.MaxDist !== 16'd12) begin
      failures++;
      $display("FAIL rerun_done: got done=%b reach=%0d max=%0d expected 1 6 12",
               if8.Done, if8.Reachable, if8.MaxDist);
    end
    if8.Finish = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem8[0] = 16'd0;    mem8[1] = 16'd5;  mem8[2] = 16'hFFFF; mem8[3] = 16'd3;
    mem8[4] = 16'd12;   mem8[5] = 16'hFFFF; mem8[6] = 16'd7;  mem8[7] = 16'd1;
    for (int k = 0; k < 4; k++) mem4[k] = 16'hFFFF;
    reset        = 1'b1;
    if8.Finish   = 1'b0;
    if8.NegCycle = 1'b0;
    if8.OutReady = 1'b0;
    if4.Finish   = 1'b0;
    if4.NegCycle = 1'b0;
    if4.OutReady = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_all_unreach();
    test_neg_idle();
    test_abort();
    test_reset_midscan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
